// File: rtl/serial_deser.sv
// serial_deser -- serial-to-parallel deserializer.
//
// Takes the q output of the upstream negedge flip-flop. It samples that bit
// on the rising edge of clk, half a cycle after q changes. WIDTH-bit words
// are assembled and presented on a valid/ready output, with a sticky overrun
// flag for words that could not be delivered.
//
// Optional feature: define PARITY_CHECK_EN to expect one even-parity bit
// after the data bits of each word. This also adds the parity_err output.
//
// Ports:
//   clk          clock; all state updates on the rising edge
//   rst          synchronous active-high reset; has priority over everything
//   din          serial data bit
//   din_en       din carries a valid bit this cycle
//   dout         assembled word (WIDTH bits)
//   dout_valid   dout holds an unconsumed word
//   dout_ready   consumer accepts dout when dout_valid=1
//   overrun      sticky: a completed word was dropped
//   overrun_clr  clears overrun (a simultaneous new drop wins)
//   state_dbg    current FSM state, for observation only
//   parity_err   (PARITY_CHECK_EN only) parity result loaded together with dout
//
// Handshake: a word transfers on any rising edge where
// dout_valid=1 and dout_ready=1. dout is held stable while dout_valid=1 and
// no transfer has occurred. dout_ready is ignored while dout_valid=0.

module serial_deser #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_en,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic [1:0]       state_dbg
`ifdef PARITY_CHECK_EN
  ,
  output logic             parity_err
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef PARITY_CHECK_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [WIDTH-1:0] sr, sr_next, shifted;
  logic             word_done;
  logic [WIDTH-1:0] word_val;
`ifdef PARITY_CHECK_EN
  logic             word_perr;
`endif

  assign state_dbg = state;

  // The first received bit ends up at the MSB when shifting left, and at the
  // LSB when shifting right.
  assign shifted = (MSB_FIRST != 0) ? {sr[WIDTH-2:0], din} : {din, sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      sr    <= sr_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    sr_next    = sr;
    word_done  = 1'b0;
    word_val   = sr;
`ifdef PARITY_CHECK_EN
    word_perr  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (din_en) begin
          sr_next    = shifted;
          cnt_next   = CNT_W'(1);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (din_en) begin
          sr_next = shifted;
          if (cnt == LAST) begin
            cnt_next = '0;
`ifdef PARITY_CHECK_EN
            state_next = PARITY;
`else
            state_next = IDLE;
            word_done  = 1'b1;
            word_val   = shifted;
`endif
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        // sr already holds the full data word; din is the parity bit.
        if (din_en) begin
          word_done  = 1'b1;
          word_val   = sr;
          word_perr  = ^{sr, din};
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Output register is separate from the shift register so assembly can
  // continue while a word waits for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (word_done && (!dout_valid || dout_ready)) begin
        // Also covers complete-plus-handshake: valid stays high, no bubble.
        dout       <= word_val;
        dout_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
        parity_err <= word_perr;
`endif
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
      // A drop on the same edge as overrun_clr leaves the flag set.
      overrun <= (word_done && dout_valid && !dout_ready) || (overrun && !overrun_clr);
    end
  end

endmodule

// File: tb/tb_serial_deser.sv
module tb_serial_deser;

  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif

  // clock / reset
  logic clk;
  logic rst, din, din_en, dout_ready, overrun_clr;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] dout_m, dout_l;
  logic         dout_valid_m, dout_valid_l, overrun_m, overrun_l;
  logic [1:0]   state_dbg_m, state_dbg_l;
`ifdef PARITY_CHECK_EN
  logic         perr_m, perr_l;
`endif

  serial_deser #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en),
    .dout(dout_m), .dout_valid(dout_valid_m), .dout_ready(dout_ready),
    .overrun(overrun_m), .overrun_clr(overrun_clr), .state_dbg(state_dbg_m)
`ifdef PARITY_CHECK_EN
    , .parity_err(perr_m)
`endif
  );

  serial_deser #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .din(din), .din_en(din_en),
    .dout(dout_l), .dout_valid(dout_valid_l), .dout_ready(dout_ready),
    .overrun(overrun_l), .overrun_clr(overrun_clr), .state_dbg(state_dbg_l)
`ifdef PARITY_CHECK_EN
    , .parity_err(perr_l)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects received bits in a list; when the list holds a
  // whole word, it builds the word by bit position and applies the output
  // handshake rules.
  logic         bits[$];
  logic [W-1:0] exp_q_m[$];
  logic [W-1:0] exp_q_l[$];
  logic         m_valid, m_over, m_perr, done;
  logic [W-1:0] m_dout_m, m_dout_l, wm, wl;
  logic         pe;

  always @(posedge clk) begin
    if (rst) begin
      bits.delete();
      exp_q_m.delete();
      exp_q_l.delete();
      m_valid = 1'b0; m_over = 1'b0; m_perr = 1'b0;
      m_dout_m = '0; m_dout_l = '0;
    end else begin
      done = 1'b0;
      if (din_en) begin
        bits.push_back(din);
        if (bits.size() == NBITS) begin
          done = 1'b1;
          pe = 1'b0;
          for (int i = 0; i < W; i++) begin
            wm[W-1-i] = bits[i];
            wl[i]     = bits[i];
          end
          for (int i = 0; i < NBITS; i++) pe = pe ^ bits[i];
          bits.delete();
        end
      end
      if (done && (!m_valid || dout_ready)) begin
        m_valid = 1'b1; m_dout_m = wm; m_dout_l = wl; m_perr = pe;
        exp_q_m.push_back(wm);
        exp_q_l.push_back(wl);
        m_over = m_over & ~overrun_clr;
      end else if (done) begin
        m_over = 1'b1;
      end else begin
        if (m_valid && dout_ready) m_valid = 1'b0;
        m_over = m_over & ~overrun_clr;
      end
    end
  end

  // Scoreboard monitor: every transfer pops the oldest expected word.
  always @(posedge clk) begin
    if (mon_on && !rst) begin
      if (dout_valid_m && dout_ready) begin
        if (exp_q_m.size() == 0) chk("xfer_m_unexpected", 32'(dout_m), 32'hFFFF_FFFF);
        else chk("xfer_m", 32'(dout_m), 32'(exp_q_m.pop_front()));
      end
      if (dout_valid_l && dout_ready) begin
        if (exp_q_l.size() == 0) chk("xfer_l_unexpected", 32'(dout_l), 32'hFFFF_FFFF);
        else chk("xfer_l", 32'(dout_l), 32'(exp_q_l.pop_front()));
      end
    end
  end

  // Cycle monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("valid_m", 32'(dout_valid_m), 32'(m_valid));
      chk("valid_l", 32'(dout_valid_l), 32'(m_valid));
      chk("overrun_m", 32'(overrun_m), 32'(m_over));
      chk("overrun_l", 32'(overrun_l), 32'(m_over));
      chk("dout_m", 32'(dout_m), 32'(m_dout_m));
      chk("dout_l", 32'(dout_l), 32'(m_dout_l));
`ifdef PARITY_CHECK_EN
      if (m_valid) begin
        chk("perr_m", 32'(perr_m), 32'(m_perr));
        chk("perr_l", 32'(perr_l), 32'(m_perr));
      end
`endif
    end
  end

  // driver tasks
  task automatic cyc(input logic b, input logic en, input logic rdy, input logic clr, input logic r);
    @(negedge clk);
    din = b; din_en = en; dout_ready = rdy; overrun_clr = clr; rst = r;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy, input logic rdy_last,
                           input logic gapped, input logic par);
    logic b;
    for (int i = 0; i < NBITS; i++) begin
      b = (i < W) ? w[W-1-i] : par;
      cyc(b, 1'b1, (i == NBITS - 1) ? rdy_last : rdy, 1'b0, 1'b0);
      if (gapped) cyc(~b, 1'b0, rdy, 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_en = 1'b1; dout_ready = 1'b0; overrun_clr = 1'b0;
    @(posedge clk);
    mon_on = 1'b1;

    // reset with activity on the inputs
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    chk("rst_dout", 32'(dout_m), 32'h0);
    chk("rst_valid", 32'(dout_valid_m), 32'h0);
    chk("rst_overrun", 32'(overrun_m), 32'h0);

    // basic words
    send_word(8'hA5, 1'b1, 1'b1, 1'b0, ^8'hA5);
    idle(1'b1);
    chk("basic_a5_m", 32'(dout_m), 32'hA5);
    chk("basic_a5_l", 32'(dout_l), 32'hA5);
    idle(1'b1);
    send_word(8'h3A, 1'b1, 1'b1, 1'b0, ^8'h3A);
    idle(1'b1);
    chk("basic_3a_m", 32'(dout_m), 32'h3A);
    chk("basic_3a_l", 32'(dout_l), 32'h5C);
    idle(1'b1);

    // gapped input
    send_word(8'h3C, 1'b1, 1'b1, 1'b1, ^8'h3C);
    idle(1'b1);
    chk("gapped_3c", 32'(dout_m), 32'h3C);
    idle(1'b1);

    // backpressure and overrun
    send_word(8'h12, 1'b0, 1'b0, 1'b0, ^8'h12);
    send_word(8'h34, 1'b0, 1'b0, 1'b0, ^8'h34);
    idle(1'b0);
    chk("bp_hold", 32'(dout_m), 32'h12);
    chk("bp_overrun", 32'(overrun_m), 32'h1);
    idle(1'b1);
    idle(1'b0);
    chk("bp_drained", 32'(dout_valid_m), 32'h0);
    chk("bp_overrun_sticky", 32'(overrun_m), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    chk("bp_overrun_clr", 32'(overrun_m), 32'h0);

    // completion on the same edge as a transfer
    send_word(8'h12, 1'b0, 1'b0, 1'b0, ^8'h12);
    send_word(8'h34, 1'b0, 1'b1, 1'b0, ^8'h34);
    idle(1'b0);
    chk("simul_dout", 32'(dout_m), 32'h34);
    chk("simul_valid", 32'(dout_valid_m), 32'h1);
    chk("simul_overrun", 32'(overrun_m), 32'h0);
    idle(1'b1);
    idle(1'b1);

    // reset mid-word, then parity cases
    for (int i = 0; i < 4; i++) cyc(i[0], 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_word(8'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk("midrst_dout", 32'(dout_m), 32'h0F);
`ifdef PARITY_CHECK_EN
    chk("par_ok", 32'(perr_m), 32'h0);
`endif
    idle(1'b1);
    send_word(8'h0F, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
`ifdef PARITY_CHECK_EN
    chk("par_bad", 32'(perr_m), 32'h1);
`endif
    idle(1'b1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 1)),
          $urandom_range(0, 9) < 7,
          $urandom_range(0, 9) < 6,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 199) == 0);
    end
    idle(1'b0);
    chk("final_q_m", 32'(exp_q_m.size()), m_valid ? 32'd1 : 32'd0);
    chk("final_q_l", 32'(exp_q_l.size()), m_valid ? 32'd1 : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_deser.md
Name: serial_deser

Overview:
- Serial-to-parallel deserializer sitting directly downstream of the negative-edge D flip-flop stage.
- Samples that stage's q output as a serial bit stream on the rising edge of clk, half a cycle after q updates.
- Assembles WIDTH-bit words and presents them on a valid/ready output with overrun detection.
- Provides the word-level consumer for the bit-level storage stage in the sequential-circuits lab.

Parameters:
- WIDTH, 8: data bits per word; legal range 2..32.
- MSB_FIRST, 1: 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  serial data bit, driven by the upstream negedge flip-flop's q.
- din_en  input  1  din is a valid bit this cycle.
- dout  output  WIDTH  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid=1.
- overrun  output  1  sticky flag: a completed word was dropped.
- overrun_clr  input  1  clears overrun.
- parity_err  output  1  present only with PARITY_CHECK_EN.

Behaviour:
- Reset: one clock synchronous reset, rst=1 at a rising edge, is the only reset.
  - rst=1 at a rising edge forces dout=0, dout_valid=0, overrun=0, parity_err=0.
  - It also clears the internal shift register and bit count, and sets state to IDLE.
  - rst has priority over every other input, including mid-word; any partial word is discarded.
- Structure:
  - Internal shift register and bit counter (0..WIDTH-1).
  - Separate output register (dout, dout_valid), so shifting continues while a word awaits the consumer.
- FSM states:
  - IDLE: count=0, no bits held. din_en=1 -> capture bit, count=1, go to SHIFT.
  - SHIFT: din_en=1 -> capture bit, count++. When the WIDTH-th bit is captured, the word is complete: count returns to 0 and state returns to IDLE. With PARITY_CHECK_EN, go to PARITY instead.
  - PARITY (macro only): the next din_en=1 bit is the parity bit; completes the word, then go to IDLE.
  - din_en=0 -> no state, count or shift change. Gaps of any length are allowed.
- Bit placement:
  - MSB_FIRST=1: shift left, new bit enters at LSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB.
- Latency: dout/dout_valid update at the same rising edge that captures the final bit, so they are visible the cycle after the final bit is presented.
- Output handshake, evaluated at each rising edge:
  - Handshake = dout_valid & dout_ready.
  - Handshake and no word completion -> dout_valid=0; dout keeps its last value.
  - Word completes and (dout_valid=0 or handshake) -> dout=new word, dout_valid=1. This also covers a simultaneous complete and handshake: valid stays 1 with no bubble.
  - Word completes while dout_valid=1 and dout_ready=0 -> new word dropped; dout unchanged; overrun=1.
  - dout_ready while dout_valid=0 is ignored.
- Overrun flag:
  - Sticky until rst or overrun_clr=1.
  - If overrun_clr and a new drop occur on the same edge, overrun=1 (set wins).
- dout is stable whenever dout_valid=1 and no handshake has occurred.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- Defined:
  - Each word is WIDTH data bits followed by one even-parity bit; PARITY state and parity_err port exist.
  - parity_err loads with dout: 1 if the XOR of the data bits and the parity bit is 1.
  - parity_err is meaningful only while dout_valid=1.
  - A dropped (overrun) word does not update parity_err.
- Undefined: no PARITY state; no parity_err port; a word is exactly WIDTH bits.

Test Plan (WIDTH=8 unless stated):
- Reset: rst=1 for 2 cycles with din_en=1, din toggling -> dout=8'h00, dout_valid=0, overrun=0 throughout and after release.
- Basic word, MSB_FIRST=1, dout_ready=1: send 8'hA5 on 8 consecutive din_en cycles -> dout=8'hA5, dout_valid high exactly 1 cycle, starting the cycle after the 8th bit. Repeat with MSB_FIRST=0, same bit sequence -> dout=8'hA5 reversed (8'hA5 is a bit-palindrome; use 8'h3A -> 8'h5C).
- Gapped input: send 8'h3C with din_en alternating 1/0, din driven opposite on din_en=0 cycles -> dout=8'h3C; bits with din_en=0 ignored.
- Backpressure: dout_ready=0, send 8'h12 then 8'h34 -> dout=8'h12 held, overrun=1 after 8'h34 completes. Then dout_ready=1 -> dout_valid=0 next edge, overrun still 1. Then overrun_clr=1 -> overrun=0.
- Simultaneous: dout_valid=1 with 8'h12; final bit of 8'h34 arrives on the same edge as dout_ready=1 -> dout=8'h34, dout_valid stays 1, overrun=0.
- Reset mid-word plus parity (PARITY_CHECK_EN):
  - 4 bits sent, then rst=1 for 1 cycle, then 8'h0F + parity 0 -> dout=8'h0F, parity_err=0.
  - Then 8'h0F + parity 1 -> parity_err=1.
